// File: rtl/i2c_slave_regctl.sv
// rtl/i2c_slave_regctl.sv - i2c_slave handshake sequencer and register file shared with a local bus
// Optional feature: define I2C_REGCTL_AUTOINC_EN for pointer post-increment after every data byte.
module i2c_slave_regctl #(
    parameter int         NREGS       = 16,
    parameter int         REG_AW      = 4,
    parameter logic [6:0] DEV_ADDR    = 7'h55,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              NRST,
    input  logic [6:0]        ADDR,
    input  logic              ARDY,
    input  logic              RW,
    input  logic [7:0]        ODATA,
    input  logic              DRDY,
    input  logic              BUSY,
    output logic [7:0]        IDATA,
    output logic              ACKA_RDY,
    output logic              ACKD_RDY,
    input  logic              LB_REQ,
    input  logic              LB_WE,
    input  logic [REG_AW-1:0] LB_ADDR,
    input  logic [7:0]        LB_WDATA,
    output logic [7:0]        LB_RDATA,
    output logic              LB_ACK,
    output logic              WR_DONE
);

`ifdef I2C_REGCTL_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam logic [REG_AW-1:0] PTR_STEP = AUTOINC ? REG_AW'(1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACKA,
        S_WAITD,
        S_WR,
        S_RD,
        S_ACKD,
        S_RELA,
        S_RELD
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] ardy_sync;
    logic [SYNC_STAGES-1:0] drdy_sync;
    logic [SYNC_STAGES-1:0] busy_sync;
    logic                   ardy_d;
    logic                   drdy_d;
    logic                   busy_d;
    logic                   ardy_s;
    logic                   drdy_s;
    logic                   busy_s;
    logic                   ardy_rise;
    logic                   ardy_fall;
    logic                   drdy_rise;
    logic                   drdy_fall;
    logic                   busy_fall;

    logic [7:0]        regs [NREGS];
    logic [REG_AW-1:0] ptr;
    logic [REG_AW-1:0] ptr_adv;
    logic              match;
    logic              ptr_set;
    logic              rw_q;
    logic [7:0]        odata_q;
    logic              stored;

    logic              addr_take;
    logic              i2c_port;
    logic              reg_we;
    logic              ptr_load;
    logic              ptr_inc;
    logic              idata_load;
    logic [7:0]        idata_val;
    logic              lb_serve;

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            ardy_sync <= '0;
            drdy_sync <= '0;
            busy_sync <= '0;
            ardy_d    <= 1'b0;
            drdy_d    <= 1'b0;
            busy_d    <= 1'b0;
        end else begin
            ardy_sync <= {ardy_sync[SYNC_STAGES-2:0], ARDY};
            drdy_sync <= {drdy_sync[SYNC_STAGES-2:0], DRDY};
            busy_sync <= {busy_sync[SYNC_STAGES-2:0], BUSY};
            ardy_d    <= ardy_s;
            drdy_d    <= drdy_s;
            busy_d    <= busy_s;
        end
    end

    assign ardy_s    = ardy_sync[SYNC_STAGES-1];
    assign drdy_s    = drdy_sync[SYNC_STAGES-1];
    assign busy_s    = busy_sync[SYNC_STAGES-1];
    assign ardy_rise = ardy_s & ~ardy_d;
    assign ardy_fall = ~ardy_s & ardy_d;
    assign drdy_rise = drdy_s & ~drdy_d;
    assign drdy_fall = ~drdy_s & drdy_d;
    assign busy_fall = ~busy_s & busy_d;
    assign ptr_adv   = ptr + PTR_STEP;

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (ardy_rise) state_next = S_ACKA;
            S_ACKA:  state_next = S_RELA;
            S_RELA:  if (ardy_fall) state_next = S_WAITD;
            S_WAITD: begin
                // STOP wins over a simultaneous repeated START or data phase
                if (busy_fall)      state_next = S_IDLE;
                else if (ardy_rise) state_next = S_ACKA;
                else if (drdy_rise) state_next = rw_q ? S_RD : S_WR;
            end
            S_WR:    state_next = S_ACKD;
            S_RD:    state_next = S_ACKD;
            S_ACKD:  state_next = S_RELD;
            S_RELD:  if (drdy_fall) state_next = S_WAITD;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        addr_take  = (state_next == S_ACKA);
        i2c_port   = 1'b0;
        reg_we     = 1'b0;
        ptr_load   = 1'b0;
        ptr_inc    = 1'b0;
        idata_load = 1'b0;
        idata_val  = 8'hFF;
        case (state)
            S_ACKA: begin
                i2c_port   = 1'b1;
                idata_load = 1'b1;
                if (match && rw_q) idata_val = regs[ptr];
            end
            S_WR: begin
                i2c_port = 1'b1;
                if (match) begin
                    if (!ptr_set) begin
                        ptr_load = 1'b1;
                    end else begin
                        reg_we  = 1'b1;
                        ptr_inc = 1'b1;
                    end
                end
            end
            S_RD: begin
                i2c_port   = 1'b1;
                idata_load = 1'b1;
                if (match) begin
                    ptr_inc   = 1'b1;
                    idata_val = regs[ptr_adv];
                end
            end
            default: ;
        endcase
        // LB_ACK high means the request just completed and is still being withdrawn
        lb_serve = LB_REQ && !LB_ACK && !i2c_port;
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
            ptr      <= '0;
            match    <= 1'b0;
            ptr_set  <= 1'b0;
            rw_q     <= 1'b0;
            odata_q  <= 8'h00;
            stored   <= 1'b0;
            IDATA    <= 8'hFF;
            ACKA_RDY <= 1'b0;
            ACKD_RDY <= 1'b0;
            LB_RDATA <= 8'h00;
            LB_ACK   <= 1'b0;
            WR_DONE  <= 1'b0;
        end else begin
            if (addr_take) begin
                match   <= (ADDR == DEV_ADDR);
                rw_q    <= RW;
                ptr_set <= 1'b0;
            end
            if (drdy_rise) odata_q <= ODATA;
            if (ptr_load) begin
                ptr     <= odata_q[REG_AW-1:0];
                ptr_set <= 1'b1;
            end else if (ptr_inc) begin
                ptr <= ptr_adv;
            end
            if (reg_we) begin
                regs[ptr] <= odata_q;
            end else if (lb_serve && LB_WE) begin
                regs[LB_ADDR] <= LB_WDATA;
            end
            if (lb_serve && !LB_WE) LB_RDATA <= regs[LB_ADDR];
            LB_ACK <= lb_serve;
            if (idata_load) IDATA <= idata_val;
            ACKA_RDY <= (state_next == S_RELA);
            ACKD_RDY <= (state_next == S_RELD);
            stored   <= (stored | reg_we) & ~busy_fall;
            WR_DONE  <= busy_fall & (stored | reg_we);
        end
    end

endmodule

// File: doc/i2c_slave_regctl.md
Name: i2c_slave_regctl

Overview:
- Controller sitting behind `i2c_slave` on the system clock. It sequences the slave's address and data handshakes and turns I2C transfers into register-file accesses.
- It owns a single-port register file and shares it between the I2C side and a local host bus. I2C has fixed priority.
- Protocol: the first write byte after the address sets the register pointer. Later write bytes store data; read bytes return register contents.

Parameters:
- NREGS, 16, number of 8-bit registers (power of two).
- REG_AW, 4, pointer/local address width, log2(NREGS).
- DEV_ADDR, 7'h55, 7-bit device address answered.
- SYNC_STAGES, 2, flops in each synchronizer for the slave-side inputs.

Ports:
- CLK  in  1  system clock.
- NRST  in  1  synchronous active-low reset.
- ADDR  in  7  received address, from i2c_slave.
- ARDY  in  1  address byte received, level, from i2c_slave.
- RW  in  1  1 = master read, from i2c_slave.
- ODATA  in  8  byte written by master.
- DRDY  in  1  data phase pending, level (write: ODATA valid; read: IDATA wanted).
- BUSY  in  1  transaction in progress (START to STOP).
- IDATA  out  8  byte to transmit on read.
- ACKA_RDY  out  1  release for the address-ACK stall.
- ACKD_RDY  out  1  release for the data-ACK stall.
- LB_REQ  in  1  local access request, held until LB_ACK.
- LB_WE  in  1  1 = write.
- LB_ADDR  in  REG_AW  local register index.
- LB_WDATA  in  8  local write data.
- LB_RDATA  out  8  local read data, valid with LB_ACK.
- LB_ACK  out  1  one-cycle completion pulse.
- WR_DONE  out  1  one-cycle pulse on BUSY fall after a matched write that stored ≥1 data byte.

Behaviour:
- Synchronization:
  - ARDY, DRDY and BUSY each pass through a SYNC_STAGES flop chain. Edges are detected on the synchronized versions.
  - ADDR, RW and ODATA are sampled only when the synchronized ARDY or DRDY rises; they are stable then.
- Handshake is 4-phase:
  - ACKx_RDY idles low, so the slave stretches SCL.
  - The controller raises ACKx_RDY after processing and holds it high until the synchronized ARDY/DRDY falls, then drops it next cycle.
- Reset (NRST low at a CLK edge), whether idle or mid-transaction:
  - state to IDLE, pointer to 0, all registers to 8'h00.
  - IDATA = 8'hFF; ACKA_RDY = ACKD_RDY = LB_ACK = WR_DONE = 0; LB_RDATA = 0; match and ptr_set flags cleared.
- FSM states: IDLE, ACKA, WAITD, WR, RD, ACKD, RELA, RELD.
  - IDLE: on ARDY rise, set match = (ADDR == DEV_ADDR) and ptr_set = 0, then go to ACKA.
  - ACKA: on a matched read, load the register at the pointer into IDATA. Otherwise IDATA = 8'hFF. Raise ACKA_RDY and go to RELA.
  - RELA: when ARDY falls, drop ACKA_RDY and go to WAITD.
  - WAITD: on DRDY rise go to WR if RW = 0, or RD if RW = 1. On ARDY rise (repeated START) re-run the IDLE decision. On BUSY fall go to IDLE.
  - WR (one cycle):
    - Mismatch: discard the byte.
    - Else if ptr_set = 0: pointer = ODATA[REG_AW-1:0] (upper bits ignored) and ptr_set = 1.
    - Else: reg[pointer] = ODATA, then advance the pointer.
    - Go to ACKD.
  - RD (one cycle): on a match, advance the pointer, then IDATA = reg[new pointer] for the next byte. Otherwise IDATA = 8'hFF. Go to ACKD.
  - ACKD: raise ACKD_RDY and go to RELD.
  - RELD: when DRDY falls, drop ACKD_RDY and go to WAITD.
- Read data timing: IDATA for the first read byte is prepared in ACKA, before the first DRDY. Each RD cycle prepares the following byte.
- Pointer advance: +1, wrapping from NREGS-1 to 0 (see the optional feature).
- Address mismatch: the controller still completes every handshake, so the bus never hangs. No register is modified and no pointer change occurs.
- Arbitration:
  - The register file does one access per cycle. The WR, RD and ACKA register accesses take the port.
  - A pending LB_REQ is served in the first cycle with no I2C access.
  - The local write, or the LB_RDATA capture, happens that cycle, and LB_ACK pulses the next cycle. Minimum latency is 1 cycle.
  - After LB_ACK, LB_REQ must drop for at least one cycle before a new request.
  - If an I2C write and a local write target the same register back to back, the later access wins.
- WR_DONE: pulses one cycle after the synchronized BUSY falls, if at least one data byte was stored in that transaction.

Optional Feature:
- Macro I2C_REGCTL_AUTOINC_EN.
- Defined: the pointer post-increments with wrap after every stored write byte and every read byte.
- Undefined: the pointer stays fixed after being set. Repeated writes overwrite one register, and repeated reads return the same register.

Test Plan:
- Write 0x55/W, bytes 0x03,0xDE,0xAD, then STOP -> reg[3]=0xDE, reg[4]=0xAD, one WR_DONE pulse, pointer=5 (AUTOINC on).
- Write 0x55/W with pointer byte 0x03, repeated START, 0x55/R, read 2 bytes (ACK then NACK) -> master sees 0xDE then 0xAD. ACKA_RDY/ACKD_RDY follow the 4-phase handshake each byte.
- Pointer 0x0F, write 0x11,0x22 -> reg[15]=0x11, reg[0]=0x22 (wrap). Without the macro: reg[15]=0x22, reg[0] unchanged.
- Address 0x22/W with bytes 0x01,0x99 -> all handshakes complete, no register changes, no WR_DONE. Address 0x22/R -> 0xFF returned.
- LB_REQ write reg[4]=0x77 held asserted during an I2C write burst -> LB_ACK only in a free cycle, no data lost. A local read returns 0x77 unless later overwritten by I2C.
- NRST low for 1 cycle in the middle of a byte -> all registers 0, ACKx_RDY=0, IDATA=0xFF. The next transaction proceeds normally.
